// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, programmable flags, sticky errors, FWFT option
// Storage is not reset; all flags are registered from the post-update occupancy.
module sync_fifo_flags #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 8,
   parameter int AF_LEVEL = 6,
   parameter int AE_LEVEL = 2,
   parameter bit FWFT     = 1'b0,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] write_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] read_data,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty,
   output logic [CW-1:0]    count,
   output logic             overflow,
   output logic             underflow,
   input  logic             clr_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, empty_q, afull_q, aempty_q;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             rd_ok, wr_ok;

   always_comb begin
      rd_ok       = rd_en && !empty_q;
      // a full FIFO can still take a write when the same edge pops a word
      wr_ok       = wr_en && (!full_q || rd_ok);
      count_d     = count_q + CW'(wr_ok) - CW'(rd_ok);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (wr_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
      overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_ok);
      underflow_d = (underflow_q && !clr_err) || (rd_en && !rd_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         afull_q     <= 1'b0;
         aempty_q    <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= (count_d == CW'(DEPTH));
         empty_q     <= (count_d == '0);
         afull_q     <= (count_d >= CW'(AF_LEVEL));
         aempty_q    <= (count_d <= CW'(AE_LEVEL));
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= write_data;
   end

   generate
      if (!FWFT) begin : g_reg_read
         logic [WIDTH-1:0] rdata_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     rdata_q <= '0;
            else if (rd_ok) rdata_q <= mem_q[rd_ptr_q];
         end
         assign read_data = rdata_q;
      end else begin : g_fwft_read
         // head word depends only on the registered read pointer
         assign read_data = mem_q[rd_ptr_q];
      end
   endgenerate

   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - bench for sync_fifo_flags (registered-read DEPTH=8 and FWFT DEPTH=5)
module tb_sync_fifo_flags;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic        wr0, rd0, clr0, full0, empty0, af0, ae0, ovf0, unf0;
   logic [15:0] wd0, rdat0;
   logic [3:0]  cnt0;
   logic        wr1, rd1, clr1, full1, empty1, af1, ae1, ovf1, unf1;
   logic [15:0] wd1, rdat1;
   logic [2:0]  cnt1;

   sync_fifo_flags #(.WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr0), .write_data(wd0), .rd_en(rd0), .read_data(rdat0),
      .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ovf0), .underflow(unf0), .clr_err(clr0));

   sync_fifo_flags #(.WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr1), .write_data(wd1), .rd_en(rd1), .read_data(rdat1),
      .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ovf1), .underflow(unf1), .clr_err(clr1));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // reference: plain queues plus sticky bits
   logic [15:0] q0[$], q1[$];
   logic [15:0] mr0;
   bit mo0, mu0, mo1, mu1;

   task automatic model_reset();
      q0.delete(); q1.delete();
      mr0 = '0; mo0 = 0; mu0 = 0; mo1 = 0; mu1 = 0;
   endtask

   task automatic model_step();
      bit r_ok, w_ok;
      r_ok = rd0 && (q0.size() > 0);
      w_ok = wr0 && (q0.size() < 8 || r_ok);
      if (r_ok) mr0 = q0.pop_front();
      if (w_ok) q0.push_back(wd0);
      mo0 = (mo0 && !clr0) || (wr0 && !w_ok);
      mu0 = (mu0 && !clr0) || (rd0 && !r_ok);
      r_ok = rd1 && (q1.size() > 0);
      w_ok = wr1 && (q1.size() < 5 || r_ok);
      if (r_ok) void'(q1.pop_front());
      if (w_ok) q1.push_back(wd1);
      mo1 = (mo1 && !clr1) || (wr1 && !w_ok);
      mu1 = (mu1 && !clr1) || (rd1 && !r_ok);
   endtask

   task automatic check_model();
      chk("m0_count", 32'(cnt0), 32'(q0.size()));
      chk("m0_full",  32'(full0),  32'(q0.size() == 8));
      chk("m0_empty", 32'(empty0), 32'(q0.size() == 0));
      chk("m0_af",    32'(af0),    32'(q0.size() >= 6));
      chk("m0_ae",    32'(ae0),    32'(q0.size() <= 2));
      chk("m0_ovf",   32'(ovf0),   32'(mo0));
      chk("m0_unf",   32'(unf0),   32'(mu0));
      chk("m0_rdata", 32'(rdat0),  32'(mr0));
      chk("m1_count", 32'(cnt1), 32'(q1.size()));
      chk("m1_full",  32'(full1),  32'(q1.size() == 5));
      chk("m1_empty", 32'(empty1), 32'(q1.size() == 0));
      chk("m1_af",    32'(af1),    32'(q1.size() >= 4));
      chk("m1_ae",    32'(ae1),    32'(q1.size() <= 1));
      chk("m1_ovf",   32'(ovf1),   32'(mo1));
      chk("m1_unf",   32'(unf1),   32'(mu1));
      if (q1.size() > 0) chk("m1_head", 32'(rdat1), 32'(q1[0]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic drive0(input logic w, input logic [15:0] d, input logic r, input logic c);
      wr0 = w; wd0 = d; rd0 = r; clr0 = c;
   endtask

   task automatic drive1(input logic w, input logic [15:0] d, input logic r, input logic c);
      wr1 = w; wd1 = d; rd1 = r; clr1 = c;
   endtask

   typedef struct {
      logic        wr;
      logic [15:0] wd;
      logic        rd;
      logic        clr;
      int          cnt;
      logic        ovf;
      logic        unf;
      logic [15:0] rdat;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(input logic w, input logic [15:0] d, input logic r, input logic c,
                               input int n, input logic o, input logic u, input logic [15:0] rd);
      vec_t v;
      v.wr = w; v.wd = d; v.rd = r; v.clr = c; v.cnt = n; v.ovf = o; v.unf = u; v.rdat = rd;
      tbl.push_back(v);
   endfunction

   initial begin
      // fill to full, one rejected write, drain, extra read, clear errors
      for (int i = 1; i <= 8; i++) add(1, 16'(i), 0, 0, i, 0, 0, 16'h0);
      add(1, 16'h0009, 0, 0, 8, 1, 0, 16'h0);
      for (int i = 1; i <= 8; i++) add(0, 16'h0, 1, 0, 8 - i, 1, 0, 16'(i));
      add(0, 16'h0, 1, 0, 0, 1, 1, 16'h0008);
      add(0, 16'h0, 0, 1, 0, 0, 0, 16'h0008);
      // simultaneous read/write on full, then drain
      for (int i = 0; i < 8; i++) add(1, 16'(16'h10 + i), 0, 0, i + 1, 0, 0, 16'h0008);
      add(1, 16'h00AA, 1, 0, 8, 0, 0, 16'h0010);
      for (int i = 1; i <= 7; i++) add(0, 16'h0, 1, 0, 8 - i, 0, 0, 16'(16'h10 + i));
      add(0, 16'h0, 1, 0, 0, 0, 0, 16'h00AA);
      // simultaneous read/write on empty
      add(1, 16'h0055, 1, 0, 1, 0, 1, 16'h00AA);
      add(0, 16'h0, 1, 0, 0, 0, 1, 16'h0055);

      rst_n = 1'b0;
      drive0(0, 0, 0, 0);
      drive1(0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 32'(cnt0), 0);
      chk("rst_empty", 32'(empty0), 1);
      chk("rst_full", 32'(full0), 0);
      chk("rst_ae", 32'(ae0), 1);
      chk("rst_af", 32'(af0), 0);
      chk("rst_ovf", 32'(ovf0), 0);
      chk("rst_unf", 32'(unf0), 0);
      chk("rst_rdata", 32'(rdat0), 0);
      chk("rst1_empty", 32'(empty1), 1);
      chk("rst1_count", 32'(cnt1), 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive0(tbl[i].wr, tbl[i].wd, tbl[i].rd, tbl[i].clr);
         cycle();
         chk($sformatf("v%0d_count", i), 32'(cnt0), 32'(tbl[i].cnt));
         chk($sformatf("v%0d_full", i), 32'(full0), 32'(tbl[i].cnt == 8));
         chk($sformatf("v%0d_empty", i), 32'(empty0), 32'(tbl[i].cnt == 0));
         chk($sformatf("v%0d_af", i), 32'(af0), 32'(tbl[i].cnt >= 6));
         chk($sformatf("v%0d_ae", i), 32'(ae0), 32'(tbl[i].cnt <= 2));
         chk($sformatf("v%0d_ovf", i), 32'(ovf0), 32'(tbl[i].ovf));
         chk($sformatf("v%0d_unf", i), 32'(unf0), 32'(tbl[i].unf));
         chk($sformatf("v%0d_rdata", i), 32'(rdat0), 32'(tbl[i].rdat));
      end
      drive0(0, 0, 0, 1);
      cycle();
      drive0(0, 0, 0, 0);

      // FWFT, depth 5: interleaved traffic across pointer wrap
      for (int k = 0; k < 12; k++) begin
         drive1(1, 16'(16'h100 + k), (k >= 2), 0);
         cycle();
         if (k == 0) chk("fwft_first_visible", 32'(rdat1), 32'h100);
      end
      drive1(0, 0, 1, 0);
      for (int k = 0; k < 8 && q1.size() > 0; k++) cycle();
      chk("fwft_drained", 32'(empty1), 1);
      drive1(0, 0, 1, 1);
      cycle();
      chk("fwft_unf_set_wins", 32'(unf1), 1);
      drive1(0, 0, 0, 0);

      // asynchronous reset mid-cycle with data stored
      for (int k = 0; k < 3; k++) begin
         drive0(1, 16'(16'h31 + k), 0, 0);
         cycle();
      end
      drive0(0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(cnt0), 0);
      chk("arst_empty", 32'(empty0), 1);
      chk("arst_ae", 32'(ae0), 1);
      chk("arst_rdata", 32'(rdat0), 0);
      chk("arst_unf1", 32'(unf1), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive0(1, 16'h0077, 0, 0);
      cycle();
      drive0(0, 0, 1, 0);
      cycle();
      chk("arst_new_word", 32'(rdat0), 32'h0077);
      chk("arst_new_empty", 32'(empty0), 1);
      drive0(0, 0, 0, 0);

      // random traffic with alternating fill/drain bias
      for (int i = 0; i < 3000; i++) begin
         int pw;
         pw = ((i / 150) % 2 == 0) ? 75 : 25;
         drive0(($urandom_range(0, 99) < pw), 16'($urandom), ($urandom_range(0, 99) >= pw),
                ($urandom_range(0, 31) == 0));
         drive1(($urandom_range(0, 99) < pw), 16'($urandom), ($urandom_range(0, 99) >= pw),
                ($urandom_range(0, 31) == 0));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
